// File: rtl/dct_row_serializer.sv
// -----------------------------------------------------------------------------
// dct_row_serializer
//
// Sits behind the DCT MAC units. Captures the NUNITS parallel accumulator
// results of one dct_block row in a single cycle, rounds (round-half-up) and
// saturates every word to the OW-bit coefficient width, then streams the
// coefficients out one per cycle in unit-index order over valid/ready.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   ena         in   global clock enable; low freezes all state and forces
//                    dout_valid / din_ready low
//   din_valid   in   a row of results is present on din
//   din         in   NUNITS*IW packed results, unit k at [k*IW +: IW]
//   din_ready   out  a row can be accepted this cycle
//   dout_valid  out  dout carries a coefficient
//   dout_ready  in   consumer takes dout this cycle
//   dout        out  rounded, saturated coefficient (signed OW bits)
//   dout_idx    out  unit index of dout
//   dout_last   out  dout is the final coefficient of the row
//   sat_clr     in   synchronous clear of sat_cnt (wins over increments)
//   sat_cnt     out  sticky-at-255 count of clipped coefficients
// -----------------------------------------------------------------------------
module dct_row_serializer #(
  parameter int NUNITS = 8,
  parameter int IW     = 22,
  parameter int OW     = 12,
  parameter int FRAC   = 10,
  localparam int IDXW  = (NUNITS > 1) ? $clog2(NUNITS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   din_valid,
  input  logic [NUNITS*IW-1:0]   din,
  output logic                   din_ready,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [OW-1:0]          dout,
  output logic [IDXW-1:0]        dout_idx,
  output logic                   dout_last,
  input  logic                   sat_clr,
  output logic [7:0]             sat_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Rounding constant 2^(FRAC-1) and clip limits, all at IW+1 bits so the
  // rounding sum can never overflow.
  localparam logic signed [IW:0] HALF  = $signed((IW+1)'(1) << (FRAC - 1));
  localparam logic signed [IW:0] MAX_R = $signed(((IW+1)'(1) << (OW - 1)) - (IW+1)'(1));
  // -2^(OW-1) is the bitwise complement of 2^(OW-1)-1.
  localparam logic signed [IW:0] MIN_R = ~MAX_R;
  localparam logic [IDXW-1:0]    LAST_IDX = IDXW'(NUNITS - 1);

  // Round-half-up: sign-extend, add half an LSB, arithmetic shift.
  function automatic logic signed [IW:0] round_word(input logic [IW-1:0] x);
    logic signed [IW:0] ext;
    ext = $signed({x[IW-1], x});
    return (ext + HALF) >>> FRAC;
  endfunction

  function automatic logic is_clipped(input logic signed [IW:0] r);
    return (r > MAX_R) || (r < MIN_R);
  endfunction

  function automatic logic [OW-1:0] saturate(input logic signed [IW:0] r);
    logic [OW-1:0] res;
    if (r > MAX_R) begin
      res = MAX_R[OW-1:0];
    end else if (r < MIN_R) begin
      res = MIN_R[OW-1:0];
    end else begin
      res = r[OW-1:0];
    end
    return res;
  endfunction

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [OW-1:0]   dout_q, dout_d;
  logic [7:0]      sat_cnt_q, sat_cnt_d;
  logic [OW-1:0]   buf_q [NUNITS];
  logic [OW-1:0]   buf_d [NUNITS];

  logic [OW-1:0]   load_word_s [NUNITS];
  logic [8:0]      clip_cnt_s;
  logic [8:0]      sat_sum_s;
  logic            last_idx_s;
  logic [IDXW-1:0] idx_inc_s;
  logic            accept_s;
  logic            transfer_s;
  logic            shifting_s;

  // Round/saturate every din word in parallel and count the clipped ones.
  // Results only reach state on an accept, so din is otherwise ignored.
  always_comb begin
    clip_cnt_s = 9'd0;
    for (int k = 0; k < NUNITS; k++) begin
      load_word_s[k] = saturate(round_word(din[k*IW +: IW]));
      clip_cnt_s     = clip_cnt_s + {8'd0, is_clipped(round_word(din[k*IW +: IW]))};
    end
  end

  // Handshake qualification; both sides are gated by ena.
  always_comb begin
    shifting_s = 1'b0;
    case (state_q)
      ST_IDLE:  shifting_s = 1'b0;
      ST_SHIFT: shifting_s = 1'b1;
      default:  shifting_s = 1'b0;
    endcase
    last_idx_s = (idx_q == LAST_IDX);
    idx_inc_s  = idx_q + IDXW'(1);
    dout_valid = ena & shifting_s;
    // Ready on the final coefficient lets the next row load with no bubble.
    din_ready  = ena & (~shifting_s | (last_idx_s & dout_ready));
    accept_s   = din_valid & din_ready;
    transfer_s = dout_valid & dout_ready;
    dout_last  = dout_valid & last_idx_s;
  end

  // Next-state logic for the row buffer, index, output word and FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    buf_d   = buf_q;
    if (accept_s) begin
      // Covers both a load from IDLE and a reload on the last transfer.
      buf_d   = load_word_s;
      dout_d  = load_word_s[0];
      idx_d   = '0;
      state_d = ST_SHIFT;
    end else if (transfer_s) begin
      if (last_idx_s) begin
        state_d = ST_IDLE;
      end else begin
        idx_d  = idx_inc_s;
        dout_d = buf_q[idx_inc_s];
      end
    end else begin
      state_d = state_q;
    end
  end

  // Saturation counter: clear wins, increments stick at 255.
  always_comb begin
    sat_sum_s = {1'b0, sat_cnt_q} + clip_cnt_s;
    sat_cnt_d = sat_cnt_q;
    if (ena & sat_clr) begin
      sat_cnt_d = 8'd0;
    end else if (accept_s) begin
      if (sat_sum_s > 9'd255) begin
        sat_cnt_d = 8'd255;
      end else begin
        sat_cnt_d = sat_sum_s[7:0];
      end
    end else begin
      sat_cnt_d = sat_cnt_q;
    end
  end

  // State registers; reset aborts any row in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      dout_q    <= '0;
      sat_cnt_q <= 8'd0;
      for (int k = 0; k < NUNITS; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dout_q    <= dout_d;
      sat_cnt_q <= sat_cnt_d;
      buf_q     <= buf_d;
    end
  end

  assign dout     = dout_q;
  assign dout_idx = idx_q;
  assign sat_cnt  = sat_cnt_q;

endmodule

// File: tb/tb_dct_row_serializer.sv
// Scoreboard bench for dct_row_serializer: rows are pushed as expected
// coefficient streams when accepted, an independent monitor pops and compares
// each transferred coefficient.
module tb_dct_row_serializer;
  localparam int NUNITS = 8;
  localparam int IW     = 22;
  localparam int OW     = 12;
  localparam int FRAC   = 10;
  localparam int IDXW   = 3;

  typedef struct {
    int coef;
    int idx;
    bit last;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ena;
  logic                 din_valid;
  logic [NUNITS*IW-1:0] din;
  logic                 din_ready;
  logic                 dout_valid;
  logic                 dout_ready;
  logic [OW-1:0]        dout;
  logic [IDXW-1:0]      dout_idx;
  logic                 dout_last;
  logic                 sat_clr;
  logic [7:0]           sat_cnt;

  dct_row_serializer #(.NUNITS(NUNITS), .IW(IW), .OW(OW), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .ena(ena), .din_valid(din_valid), .din(din),
    .din_ready(din_ready), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout(dout), .dout_idx(dout_idx), .dout_last(dout_last),
    .sat_clr(sat_clr), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;
  int   model_sat = 0;

  // back-to-back observation
  bit   b2b_en = 1'b0;
  int   ncyc = 0;
  int   b2b_valid = 0, b2b_first = -1, b2b_last = -1, b2b_rdy7 = 0, b2b_rdy_other = 0;

  // hold observation
  bit   hold_pending = 1'b0;
  int   h_dout = 0, h_idx = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: floor((x + 2^(FRAC-1)) / 2^FRAC), then clip to OW-bit signed.
  function automatic int model_coef(input longint x, output bit clipped);
    longint scale, num, q, hi, lo;
    scale = longint'(1) << FRAC;
    num   = x + scale / 2;
    q     = num / scale;
    if (num < 0 && (num % scale) != 0) q = q - 1;
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -(longint'(1) << (OW - 1));
    clipped = 1'b0;
    if (q > hi) begin q = hi; clipped = 1'b1; end
    else if (q < lo) begin q = lo; clipped = 1'b1; end
    return int'(q);
  endfunction

  // Input side: on every accept, push the expected coefficient stream.
  always @(negedge clk) begin
    if (rst) begin
      if (din_valid && din_ready) begin
        for (int k = 0; k < NUNITS; k++) begin
          longint x;
          bit     c;
          exp_t   e;
          x      = longint'($signed(din[k*IW +: IW]));
          e.coef = model_coef(x, c);
          e.idx  = k;
          e.last = (k == NUNITS - 1);
          sb_q.push_back(e);
          if (c && model_sat < 255) model_sat++;
        end
      end
      if (ena && sat_clr) model_sat = 0;
    end
  end

  // Output side: compare every transfer, and check hold/gating rules.
  always @(negedge clk) begin
    ncyc++;
    if (!rst) begin
      hold_pending = 1'b0;
    end else begin
      if (!ena) begin
        check("valid_gated", dout_valid, 0);
        check("ready_gated", din_ready, 0);
      end
      if (!dout_valid) check("last_idle", dout_last, 0);
      if (dout_valid && !dout_ready) check("stall_din_ready", din_ready, 0);
      if (hold_pending) begin
        check("hold_dout", int'($signed(dout)), h_dout);
        check("hold_idx", dout_idx, h_idx);
      end
      if (dout_valid && dout_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("dout", int'($signed(dout)), e.coef);
          check("dout_idx", dout_idx, e.idx);
          check("dout_last", dout_last, e.last);
        end
      end
      if (b2b_en) begin
        if (dout_valid) begin
          b2b_valid++;
          if (b2b_first < 0) b2b_first = ncyc;
          b2b_last = ncyc;
          if (din_ready) begin
            if (dout_idx == 3'(NUNITS - 1)) b2b_rdy7++;
            else b2b_rdy_other++;
          end
        end
      end
      if ((dout_valid && !dout_ready) || (!ena && sb_q.size() > 0)) begin
        if (!hold_pending || dout_valid) begin
          h_dout = int'($signed(dout));
          h_idx  = int'(dout_idx);
        end
        hold_pending = 1'b1;
      end else begin
        hold_pending = 1'b0;
      end
    end
  end

  function automatic logic [NUNITS*IW-1:0] pack_row(input int w[NUNITS]);
    logic [NUNITS*IW-1:0] r;
    r = '0;
    for (int k = 0; k < NUNITS; k++) r[k*IW +: IW] = w[k][IW-1:0];
    return r;
  endfunction

  function automatic logic [NUNITS*IW-1:0] rand_row();
    int w[NUNITS];
    for (int k = 0; k < NUNITS; k++) begin
      case ($urandom_range(0, 2))
        0:       w[k] = int'($urandom_range(0, 8000)) - 4000;
        1:       w[k] = int'($urandom_range(0, 200000)) + 2000000
                        - ((($urandom & 1) == 1) ? 4200000 : 0);
        default: w[k] = int'($urandom);
      endcase
    end
    return pack_row(w);
  endfunction

  // Present a row and wait (bounded) until it is accepted.
  task automatic send_row(input logic [NUNITS*IW-1:0] row, input bit chk_lat);
    bit acc;
    int n;
    acc = 1'b0;
    din = row;
    din_valid = 1'b1;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      acc = din_valid && din_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    din_valid = 1'b0;
    check("accept_timeout", acc, 1);
    if (chk_lat && acc) begin
      check("latency_valid", dout_valid, 1);
      check("latency_idx", dout_idx, 0);
    end
  endtask

  task automatic drain();
    ena = 1'b1;
    dout_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_idx(input int target);
    int n;
    for (n = 0; n < 40; n++) begin
      if (dout_valid && dout_idx == 3'(target)) break;
      @(posedge clk); #1;
    end
    check("wait_idx_timeout", (n < 40) ? 1 : 0, 1);
  endtask

  initial begin
    int w[NUNITS];
    bit acc;
    rst = 1'b0; ena = 1'b1; din_valid = 1'b0; din = '0;
    dout_ready = 1'b1; sat_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", dout_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_idx", dout_idx, 0);
    check("rst_last", dout_last, 0);
    check("rst_sat", sat_cnt, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Ramp row: k*1024+512 rounds to k+1.
    for (int k = 0; k < NUNITS; k++) w[k] = k * 1024 + 512;
    send_row(pack_row(w), 1'b1);
    drain();
    check("sat_after_ramp", sat_cnt, model_sat);

    // Negative rounding row.
    w = '{-1536, -512, -513, 511, 0, -1, 1023, -1024};
    send_row(pack_row(w), 1'b1);
    drain();

    // Saturation row, then clear.
    w = '{2096640, -2097152, 2047*1024, -2048*1024, 0, 0, 0, 0};
    send_row(pack_row(w), 1'b1);
    drain();
    check("sat_cnt_loaded", sat_cnt, model_sat);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    check("sat_cnt_cleared", sat_cnt, model_sat);

    // Back-to-back: three rows with din_valid held high.
    b2b_en = 1'b1;
    din = rand_row();
    din_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      acc = 1'b0;
      for (int n = 0; n < 40 && !acc; n++) begin
        @(negedge clk);
        acc = din_valid && din_ready;
        @(posedge clk); #1;
      end
      check("b2b_accept", acc, 1);
      if (r < 2) din = rand_row();
    end
    din_valid = 1'b0;
    drain();
    b2b_en = 1'b0;
    check("b2b_valid_cycles", b2b_valid, 24);
    check("b2b_no_bubble", b2b_last - b2b_first + 1, 24);
    check("b2b_ready_idx7", b2b_rdy7, 3);
    check("b2b_ready_other", b2b_rdy_other, 0);

    // Backpressure at idx 3, ena low at idx 5.
    send_row(rand_row(), 1'b1);
    wait_idx(3);
    dout_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("stall_idx", dout_idx, 3);
    dout_ready = 1'b1;
    wait_idx(5);
    ena = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("ena_idx", dout_idx, 5);
    ena = 1'b1;
    drain();

    // Reset mid-row with a row waiting on din.
    send_row(rand_row(), 1'b1);
    wait_idx(4);
    din = rand_row();
    din_valid = 1'b1;
    rst = 1'b0;
    sb_q.delete();
    model_sat = 0;
    #1;
    check("midrst_valid", dout_valid, 0);
    check("midrst_dout", dout, 0);
    check("midrst_idx", dout_idx, 0);
    check("midrst_last", dout_last, 0);
    check("midrst_sat", sat_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    send_row(din, 1'b1);
    drain();

    // Random traffic with random backpressure, ena and sat_clr.
    din_valid = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc = din_valid && din_ready;
      @(posedge clk); #1;
      ena        = ($urandom_range(0, 9) != 0);
      dout_ready = ($urandom_range(0, 9) < 7);
      sat_clr    = ($urandom_range(0, 49) == 0);
      if (acc || !din_valid) begin
        din       = rand_row();
        din_valid = ($urandom_range(0, 3) != 0);
      end
      if ((c % 100) == 50) check("sat_cnt_rand", sat_cnt, model_sat);
    end
    din_valid = 1'b0;
    sat_clr = 1'b0;
    drain();
    check("sat_cnt_final", sat_cnt, model_sat);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
